// File: rtl/pwm_demod.sv
// pwm_demod: recovers a centred duty-cycle sample (2*high - period) and the period from a PWM stream.
// Optional 4-tap boxcar on the output sample when PWM_DEMOD_AVG_EN is defined.
module pwm_demod #(
    parameter int CNT_W      = 17,
    parameter int MIN_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pwm_in,
    output logic signed [CNT_W:0] sample_out,
    output logic [CNT_W-1:0]      period_out,
    output logic                  sample_valid,
    output logic                  stuck,
    output logic [7:0]            glitch_cnt
);
    localparam logic [CNT_W-1:0]   MAX_PERIOD = '1;
    localparam logic [CNT_W-1:0]   MIN_P      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]   ONE        = CNT_W'(1);
    localparam logic signed [CNT_W:0] POS_FULL = {1'b0, MAX_PERIOD};
    localparam logic signed [CNT_W:0] NEG_FULL = -POS_FULL;

    typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;
    state_t state, state_nxt;

    logic                  pwm_m, pwm_s, pwm_d, rise;
    logic [CNT_W-1:0]      period_cnt, high_cnt, period_nxt, high_nxt;
    logic [CNT_W:0]        duty_diff;
    logic                  emit, glitch;
    logic signed [CNT_W:0] emit_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {pwm_m, pwm_s, pwm_d} <= '0;
        end else begin
            pwm_m <= pwm_in;
            pwm_s <= pwm_m;
            pwm_d <= pwm_s;
        end
    end

    assign rise      = pwm_s & ~pwm_d;
    // Modular CNT_W+1-bit difference is exact because 0 <= high <= period.
    assign duty_diff = {high_cnt, 1'b0} - {1'b0, period_cnt};
    assign stuck     = (state == TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            period_cnt <= period_nxt;
            high_cnt   <= high_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        period_nxt  = (period_cnt == MAX_PERIOD) ? period_cnt : period_cnt + ONE;
        high_nxt    = (pwm_s && high_cnt != MAX_PERIOD) ? high_cnt + ONE : high_cnt;
        emit        = 1'b0;
        glitch      = 1'b0;
        emit_sample = $signed(duty_diff);
        if (!enable) begin
            state_nxt  = IDLE;
            period_nxt = '0;
            high_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    period_nxt = '0;
                    high_nxt   = '0;
                    if (rise) begin
                        state_nxt  = MEASURE;
                        period_nxt = ONE;
                        high_nxt   = ONE;
                    end
                end
                MEASURE: begin
                    // The edge cycle is counted as the first cycle of the new period.
                    if (rise) begin
                        period_nxt = ONE;
                        high_nxt   = ONE;
                        if (period_cnt >= MIN_P) emit = 1'b1;
                        else                     glitch = 1'b1;
                    end else if (period_cnt == MAX_PERIOD) begin
                        state_nxt   = TIMEOUT;
                        emit        = 1'b1;
                        emit_sample = pwm_s ? POS_FULL : NEG_FULL;
                    end
                end
                TIMEOUT: begin
                    if (rise) begin
                        state_nxt  = MEASURE;
                        period_nxt = ONE;
                        high_nxt   = ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) glitch_cnt <= '0;
        else if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
    end

`ifdef PWM_DEMOD_AVG_EN
    logic signed [CNT_W:0]   tap0, tap1, tap2, tap3;
    logic signed [CNT_W+2:0] tap_sum;
    logic                    pend_valid, fill;
    logic [CNT_W-1:0]        pend_period;

    assign fill    = (state == MEASURE) && (state_nxt == TIMEOUT);
    assign tap_sum = (CNT_W+3)'(tap0) + (CNT_W+3)'(tap1) + (CNT_W+3)'(tap2) + (CNT_W+3)'(tap3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {tap0, tap1, tap2, tap3} <= '0;
            pend_valid   <= 1'b0;
            pend_period  <= '0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
            period_out   <= '0;
        end else if (!enable) begin
            {tap0, tap1, tap2, tap3} <= '0;
            pend_valid   <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            pend_valid   <= emit;
            sample_valid <= pend_valid;
            if (emit) begin
                pend_period <= period_cnt;
                tap0 <= emit_sample;
                tap1 <= fill ? emit_sample : tap0;
                tap2 <= fill ? emit_sample : tap1;
                tap3 <= fill ? emit_sample : tap2;
            end
            if (pend_valid) begin
                sample_out <= (CNT_W+1)'(tap_sum >>> 2);
                period_out <= pend_period;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_out   <= '0;
            period_out   <= '0;
        end else begin
            sample_valid <= emit;
            if (emit) begin
                sample_out <= emit_sample;
                period_out <= period_cnt;
            end
        end
    end
`endif

endmodule
